// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_e  - controller state encoding (IDLE, RUN, DONE)
//   cnt_w()  - bit-counter width for a given operand width
//   WIDTH_MIN / WIDTH_MAX - legal operand width range
package serial_adder_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter only has to reach w-1, so $clog2(w) bits suffice (min 1).
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// fa_bit_cell: combinational 1-bit full adder.
//   a, b, ci : operand bits and carry-in
//   s, co    : sum bit and carry-out
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around one fa_bit_cell.
// Operands are captured on an accepted start, then one bit per cycle is
// processed LSB first; the result is published on sum/cout with a one-cycle
// done pulse.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request, sampled only in IDLE
//   a, b, cin       : operands and carry-in, captured on accepted start
//   sub             : subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy            : high while bits are being processed
//   done            : one-cycle pulse when sum/cout are updated
//   sum, cout       : registered result and carry-out of bit WIDTH-1
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds sub port, a - b).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
    $error("serial_adder_ctrl: WIDTH out of legal range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             cell_s, cell_co;

  fa_bit_cell u_cell (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // Operand/carry values loaded on acceptance; subtract is a + ~b + 1.
  logic [WIDTH-1:0] b_load;
  logic             c_load;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = c_load;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Result fills from the MSB end so bit 0 lands at [0] after WIDTH shifts.
        res_sr_d = {cell_s, res_sr_q[WIDTH-1:1]};
        carry_d  = cell_co;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = {cell_s, res_sr_q[WIDTH-1:1]};
          cout_d  = cell_co;
          cnt_d   = '0;  // keep the counter from wrapping past WIDTH-1
          carry_d = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
